writeback_stage_p: RTL and testbench

- Parametrised, registered successor to the combinational writeback pass-through in the pipelined core.
- Holds the MEM/WB pipeline register and selects the result source (ALU, memory, PC+4).
- Aligns and sign/zero-extends load data, checks load alignment, suppresses writes to x0 and bubbles, and counts retired instructions.
- Drives the register-file write port and the WB-stage forwarding path.

---
 rtl/writeback_stage_p.sv | 165 ++++++++++++++++
 tb/tb_writeback_stage_p.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage_p.sv
// ---------------------------------------------------------------------------
// writeback_stage_p
//
// Registered writeback stage for the pipelined core. Holds the MEM/WB pipeline
// register, picks the result source (ALU, formatted load data, PC+4), aligns
// and extends load data, flags misaligned loads, suppresses writes to x0 and
// bubbles, and counts retired instructions.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   in_valid          MEM stage presents a real instruction
//   stall, flush      hold the stage register / insert a bubble (flush wins)
//   alu_result        ALU result
//   mem_result        raw aligned-word read data from memory
//   pc_plus4          link value for JAL/JALR
//   wb_sel            00 ALU, 01 load, 10 PC+4, 11 ALU
//   load_funct3       load type (LB/LH/LW/LD/LBU/LHU/LWU)
//   byte_offset       low address bits of the load
//   reg_write, rd_addr  instruction writes rd / destination register
//   write_back_data   registered write data
//   write_back_addr   registered destination register
//   reg_write_back    register-file write enable
//   wb_valid          stage holds a real instruction
//   load_misaligned   registered misaligned-load flag
//   instret_count     retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module writeback_stage_p #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned OFF_W  = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        load_funct3,
  input  logic [OFF_W-1:0]  byte_offset,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   write_back_data,
  output logic [REG_AW-1:0] write_back_addr,
  output logic              reg_write_back,
  output logic              wb_valid,
  output logic              load_misaligned,
  output logic [CNT_W-1:0]  instret_count
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // ------------------------------------------------------------------------
  // Load data alignment and extension
  // ------------------------------------------------------------------------
  logic [OFF_W+2:0] w_shift_amt;
  logic [XLEN-1:0]  w_shifted;
  logic [XLEN-1:0]  w_load_data;

  assign w_shift_amt = {byte_offset, 3'b000};
  assign w_shifted   = mem_result >> w_shift_amt;

  // With XLEN=32 the LWU/LD/LDU-style encodings collapse onto LW naturally:
  // a 32-bit value extended to 32 bits is the full shifted word.
  always_comb begin
    w_load_data = w_shifted;
    case (load_funct3)
      3'b000:  w_load_data = XLEN'($signed(w_shifted[7:0]));
      3'b100:  w_load_data = XLEN'(w_shifted[7:0]);
      3'b001:  w_load_data = XLEN'($signed(w_shifted[15:0]));
      3'b101:  w_load_data = XLEN'(w_shifted[15:0]);
      3'b010:  w_load_data = XLEN'($signed(w_shifted[31:0]));
      3'b110:  w_load_data = XLEN'(w_shifted[31:0]);
      default: w_load_data = w_shifted;
    endcase
  end

  // ------------------------------------------------------------------------
  // Misalignment: offset bits below the access size must be zero.
  // An 8-byte mask truncated to a 2-bit offset gives the LW mask on XLEN=32.
  // ------------------------------------------------------------------------
  logic [2:0]       w_size_mask;
  logic [OFF_W-1:0] w_align_mask;
  logic             w_misaligned;

  always_comb begin
    w_size_mask = 3'b000;
    case (load_funct3[1:0])
      2'b00:   w_size_mask = 3'b000;
      2'b01:   w_size_mask = 3'b001;
      2'b10:   w_size_mask = 3'b011;
      default: w_size_mask = 3'b111;
    endcase
  end

  assign w_align_mask = OFF_W'(w_size_mask);
  assign w_misaligned = (wb_sel == WB_LOAD) && ((byte_offset & w_align_mask) != '0);

  // ------------------------------------------------------------------------
  // Result source select
  // ------------------------------------------------------------------------
  logic [XLEN-1:0] w_result;

  always_comb begin
    w_result = alu_result;
    case (wb_sel)
      WB_LOAD: w_result = w_load_data;
      WB_PC4:  w_result = pc_plus4;
      default: w_result = alu_result;
    endcase
  end

  logic w_we_next;
  assign w_we_next = in_valid & reg_write & (rd_addr != '0) & ~w_misaligned;

  // ------------------------------------------------------------------------
  // MEM/WB stage register
  // ------------------------------------------------------------------------
  logic [XLEN-1:0]   r_data;
  logic [REG_AW-1:0] r_addr;
  logic              r_we;
  logic              r_valid;
  logic              r_misaligned;
  logic [CNT_W-1:0]  r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
      r_instret    <= '0;
    end else if (flush) begin
      r_data       <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (!stall) begin
      r_data       <= w_result;
      r_addr       <= rd_addr;
      r_we         <= w_we_next;
      r_valid      <= in_valid;
      r_misaligned <= in_valid & w_misaligned;
      // Reaching here with in_valid set is exactly a capture edge.
      if (in_valid && !w_misaligned) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign write_back_data = r_data;
  assign write_back_addr = r_addr;
  assign reg_write_back  = r_we;
  assign wb_valid        = r_valid;
  assign load_misaligned = r_misaligned;
  assign instret_count   = r_instret;

endmodule

// File: tb/tb_writeback_stage_p.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage_p
//
// Directed bench for writeback_stage_p: a default XLEN=64/CNT_W=64 instance
// plus a CNT_W=4 instance sharing the same stimulus for the wrap case.
// ---------------------------------------------------------------------------
module tb_writeback_stage_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, flush, reg_write;
  logic [63:0] alu_result, mem_result, pc_plus4;
  logic [1:0]  wb_sel;
  logic [2:0]  load_funct3;
  logic [2:0]  byte_offset;
  logic [4:0]  rd_addr;

  logic [63:0] o_data;
  logic [4:0]  o_addr;
  logic        o_we, o_valid, o_mis;
  logic [63:0] o_cnt;

  logic [63:0] c4_data;
  logic [4:0]  c4_addr;
  logic        c4_we, c4_valid, c4_mis;
  logic [3:0]  c4_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [63:0] exp_cnt  = '0;

  localparam logic [63:0] MEMW = 64'h1122_3344_8899_AABB;

  always #5 clk = ~clk;

  writeback_stage_p #(.XLEN(64), .REG_AW(5), .CNT_W(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .mem_result(mem_result), .pc_plus4(pc_plus4),
    .wb_sel(wb_sel), .load_funct3(load_funct3), .byte_offset(byte_offset),
    .reg_write(reg_write), .rd_addr(rd_addr),
    .write_back_data(o_data), .write_back_addr(o_addr), .reg_write_back(o_we),
    .wb_valid(o_valid), .load_misaligned(o_mis), .instret_count(o_cnt)
  );

  writeback_stage_p #(.XLEN(64), .REG_AW(5), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .mem_result(mem_result), .pc_plus4(pc_plus4),
    .wb_sel(wb_sel), .load_funct3(load_funct3), .byte_offset(byte_offset),
    .reg_write(reg_write), .rd_addr(rd_addr),
    .write_back_data(c4_data), .write_back_addr(c4_addr), .reg_write_back(c4_we),
    .wb_valid(c4_valid), .load_misaligned(c4_mis), .instret_count(c4_cnt)
  );

  task automatic set_in(input logic v, input logic [1:0] sel, input logic [63:0] alu,
                        input logic [63:0] mem, input logic [63:0] pc, input logic [2:0] f3,
                        input logic [2:0] off, input logic rw, input logic [4:0] rd);
    in_valid = v; wb_sel = sel; alu_result = alu; mem_result = mem; pc_plus4 = pc;
    load_funct3 = f3; byte_offset = off; reg_write = rw; rd_addr = rd;
  endtask

  task automatic idle();
    set_in(1'b0, 2'b00, '0, '0, '0, 3'b000, 3'b000, 1'b0, 5'd0);
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; idle();
    #2;
    checks++;
    if ({o_data, o_addr, o_we, o_valid, o_mis, o_cnt} !== '0) begin
      failures++; $display("FAIL reset_initial data=%h addr=%0d we=%b v=%b mis=%b cnt=%0d want all 0",
                           o_data, o_addr, o_we, o_valid, o_mis, o_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    set_in(1'b1, 2'b00, 64'hABCD, '0, '0, 3'b000, 3'b000, 1'b1, 5'd4);
    tick(); exp_cnt = 1;
    checks++;
    if ({o_data, o_addr, o_we, o_valid, o_cnt} !== {64'hABCD, 5'd4, 1'b1, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL reset_prep data=%h addr=%0d we=%b v=%b cnt=%0d want abcd/4/1/1/1",
                           o_data, o_addr, o_we, o_valid, o_cnt);
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++;
    if ({o_data, o_addr, o_we, o_valid, o_mis, o_cnt} !== '0) begin
      failures++; $display("FAIL reset_async data=%h addr=%0d we=%b v=%b mis=%b cnt=%0d want all 0",
                           o_data, o_addr, o_we, o_valid, o_mis, o_cnt);
    end
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if ({o_data, o_addr, o_we, o_valid, o_mis, o_cnt} !== '0) begin
      failures++; $display("FAIL reset_stays0 data=%h addr=%0d we=%b v=%b mis=%b cnt=%0d want all 0",
                           o_data, o_addr, o_we, o_valid, o_mis, o_cnt);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_stall();
    set_in(1'b1, 2'b00, 64'h55, '0, '0, 3'b000, 3'b000, 1'b1, 5'd6);
    tick(); exp_cnt++;
    stall = 1'b1;
    set_in(1'b1, 2'b00, 64'h66, '0, '0, 3'b000, 3'b000, 1'b1, 5'd7);
    tick();
    checks++;
    if ({o_data, o_addr, o_we, o_cnt} !== {64'h55, 5'd6, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL rst_stall_hold data=%h addr=%0d we=%b cnt=%0d want 55/6/1/%0d",
                           o_data, o_addr, o_we, o_cnt, exp_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++;
    if ({o_data, o_addr, o_we, o_valid, o_cnt} !== '0) begin
      failures++; $display("FAIL rst_mid_stall data=%h addr=%0d we=%b v=%b cnt=%0d want all 0",
                           o_data, o_addr, o_we, o_valid, o_cnt);
    end
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if ({o_data, o_addr, o_we, o_valid, o_cnt} !== '0) begin
      failures++; $display("FAIL rst_stall_after data=%h addr=%0d we=%b v=%b cnt=%0d want all 0",
                           o_data, o_addr, o_we, o_valid, o_cnt);
    end
    idle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_load_ext();
    // LH, offset 2: halfword 0x8899 sign-extended
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b001, 3'd2, 1'b1, 5'd7);
    #1;
    checks++;
    if (o_data !== 64'h0) begin
      failures++; $display("FAIL no_comb_path data=%h want 0 before edge", o_data);
    end
    tick(); exp_cnt++;
    checks++;
    if ({o_data, o_addr, o_we, o_mis, o_cnt} !== {64'hFFFF_FFFF_FFFF_8899, 5'd7, 1'b1, 1'b0, exp_cnt}) begin
      failures++; $display("FAIL lh_sign data=%h addr=%0d we=%b mis=%b cnt=%0d want ffffffffffff8899/7/1/0/%0d",
                           o_data, o_addr, o_we, o_mis, o_cnt, exp_cnt);
    end
    // LHU, same data
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b101, 3'd2, 1'b1, 5'd7);
    tick(); exp_cnt++;
    checks++;
    if ({o_data, o_we, o_cnt} !== {64'h0000_0000_0000_8899, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL lhu_zero data=%h we=%b cnt=%0d want 8899/1/%0d", o_data, o_we, o_cnt, exp_cnt);
    end
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b000, 3'd0, 1'b1, 5'd8);
    tick(); exp_cnt++;
    checks++;
    if (o_data !== 64'hFFFF_FFFF_FFFF_FFBB) begin
      failures++; $display("FAIL lb_sign data=%h want ffffffffffffffbb", o_data);
    end
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b100, 3'd7, 1'b1, 5'd8);
    tick(); exp_cnt++;
    checks++;
    if (o_data !== 64'h11) begin
      failures++; $display("FAIL lbu_off7 data=%h want 11", o_data);
    end
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b000, 3'd5, 1'b1, 5'd8);
    tick(); exp_cnt++;
    checks++;
    if (o_data !== 64'h33) begin
      failures++; $display("FAIL lb_off5 data=%h want 33", o_data);
    end
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b010, 3'd0, 1'b1, 5'd9);
    tick(); exp_cnt++;
    checks++;
    if (o_data !== 64'hFFFF_FFFF_8899_AABB) begin
      failures++; $display("FAIL lw_sign data=%h want ffffffff8899aabb", o_data);
    end
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b110, 3'd4, 1'b1, 5'd9);
    tick(); exp_cnt++;
    checks++;
    if (o_data !== 64'h1122_3344) begin
      failures++; $display("FAIL lwu_off4 data=%h want 11223344", o_data);
    end
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b011, 3'd0, 1'b1, 5'd10);
    tick(); exp_cnt++;
    checks++;
    if ({o_data, o_we, o_cnt} !== {MEMW, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL ld_full data=%h we=%b cnt=%0d want %h/1/%0d", o_data, o_we, o_cnt, MEMW, exp_cnt);
    end
    idle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_source_select();
    set_in(1'b1, 2'b10, 64'hBAD, MEMW, 64'h1004, 3'b000, 3'd0, 1'b1, 5'd5);
    tick(); exp_cnt++;
    checks++;
    if ({o_data, o_addr, o_we, o_valid, o_cnt} !== {64'h1004, 5'd5, 1'b1, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL sel_pc4 data=%h addr=%0d we=%b v=%b cnt=%0d want 1004/5/1/1/%0d",
                           o_data, o_addr, o_we, o_valid, o_cnt, exp_cnt);
    end
    set_in(1'b1, 2'b10, 64'hBAD, MEMW, 64'h1004, 3'b000, 3'd0, 1'b1, 5'd0);
    tick(); exp_cnt++;
    checks++;
    if ({o_data, o_addr, o_we, o_valid, o_cnt} !== {64'h1004, 5'd0, 1'b0, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL sel_x0 data=%h addr=%0d we=%b v=%b cnt=%0d want 1004/0/0/1/%0d",
                           o_data, o_addr, o_we, o_valid, o_cnt, exp_cnt);
    end
    set_in(1'b1, 2'b11, 64'hDEAD, MEMW, 64'h1004, 3'b000, 3'd0, 1'b1, 5'd2);
    tick(); exp_cnt++;
    checks++;
    if ({o_data, o_addr, o_we} !== {64'hDEAD, 5'd2, 1'b1}) begin
      failures++; $display("FAIL sel_11_alu data=%h addr=%0d we=%b want dead/2/1", o_data, o_addr, o_we);
    end
    // store-like instruction: counted though it never writes
    set_in(1'b1, 2'b00, 64'h40, MEMW, '0, 3'b000, 3'd0, 1'b0, 5'd3);
    tick(); exp_cnt++;
    checks++;
    if ({o_we, o_valid, o_cnt} !== {1'b0, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL no_regwrite we=%b v=%b cnt=%0d want 0/1/%0d", o_we, o_valid, o_cnt, exp_cnt);
    end
    idle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_misaligned();
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b010, 3'd2, 1'b1, 5'd11);
    tick();
    checks++;
    if ({o_data, o_mis, o_we, o_valid, o_cnt} !== {64'h3344_8899, 1'b1, 1'b0, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL mis_lw data=%h mis=%b we=%b v=%b cnt=%0d want 33448899/1/0/1/%0d",
                           o_data, o_mis, o_we, o_valid, o_cnt, exp_cnt);
    end
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b011, 3'd4, 1'b1, 5'd11);
    tick();
    checks++;
    if ({o_data, o_mis, o_we, o_cnt} !== {64'h1122_3344, 1'b1, 1'b0, exp_cnt}) begin
      failures++; $display("FAIL mis_ld data=%h mis=%b we=%b cnt=%0d want 11223344/1/0/%0d",
                           o_data, o_mis, o_we, o_cnt, exp_cnt);
    end
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b001, 3'd1, 1'b1, 5'd11);
    tick();
    checks++;
    if ({o_data, o_mis, o_we} !== {64'hFFFF_FFFF_FFFF_99AA, 1'b1, 1'b0}) begin
      failures++; $display("FAIL mis_lh data=%h mis=%b we=%b want ffffffffffff99aa/1/0", o_data, o_mis, o_we);
    end
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b100, 3'd3, 1'b1, 5'd11);
    tick(); exp_cnt++;
    checks++;
    if ({o_data, o_mis, o_we, o_cnt} !== {64'h88, 1'b0, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL lbu_odd data=%h mis=%b we=%b cnt=%0d want 88/0/1/%0d",
                           o_data, o_mis, o_we, o_cnt, exp_cnt);
    end
    set_in(1'b1, 2'b00, 64'h77, MEMW, '0, 3'b010, 3'd3, 1'b1, 5'd11);
    tick(); exp_cnt++;
    checks++;
    if ({o_data, o_mis, o_we, o_cnt} !== {64'h77, 1'b0, 1'b1, exp_cnt}) begin
      failures++; $display("FAIL alu_not_mis data=%h mis=%b we=%b cnt=%0d want 77/0/1/%0d",
                           o_data, o_mis, o_we, o_cnt, exp_cnt);
    end
    idle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stall_flush();
    set_in(1'b1, 2'b00, 64'd7, '0, '0, 3'b000, 3'd0, 1'b1, 5'd3);
    tick(); exp_cnt++;
    set_in(1'b1, 2'b00, 64'd99, '0, '0, 3'b000, 3'd0, 1'b1, 5'd9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o_data, o_addr, o_we, o_valid, o_cnt} !== {64'd7, 5'd3, 1'b1, 1'b1, exp_cnt}) begin
        failures++; $display("FAIL stall_hold[%0d] data=%h addr=%0d we=%b v=%b cnt=%0d want 7/3/1/1/%0d",
                             i, o_data, o_addr, o_we, o_valid, o_cnt, exp_cnt);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if ({o_data, o_addr, o_we, o_valid, o_mis, o_cnt} !== {64'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_cnt}) begin
      failures++; $display("FAIL stall_flush data=%h addr=%0d we=%b v=%b mis=%b cnt=%0d want 0/0/0/0/0/%0d",
                           o_data, o_addr, o_we, o_valid, o_mis, o_cnt, exp_cnt);
    end
    // misaligned flag is cleared by a plain flush
    stall = 1'b0; flush = 1'b0;
    set_in(1'b1, 2'b01, '0, MEMW, '0, 3'b001, 3'd1, 1'b1, 5'd4);
    tick();
    flush = 1'b1;
    tick();
    checks++;
    if ({o_we, o_valid, o_mis, o_cnt} !== {1'b0, 1'b0, 1'b0, exp_cnt}) begin
      failures++; $display("FAIL flush_only we=%b v=%b mis=%b cnt=%0d want 0/0/0/%0d",
                           o_we, o_valid, o_mis, o_cnt, exp_cnt);
    end
    idle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [63:0] vals [4];
    vals[0] = 64'h1; vals[1] = 64'hFFFF_0000_1234_5678; vals[2] = 64'h8000_0000_0000_0000; vals[3] = 64'h2A;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'b00, vals[i], '0, '0, 3'b000, 3'd0, 1'b1, 5'(i + 20));
      tick(); exp_cnt++;
      checks++;
      if ({o_data, o_addr, o_we, o_cnt} !== {vals[i], 5'(i + 20), 1'b1, exp_cnt}) begin
        failures++; $display("FAIL b2b[%0d] data=%h addr=%0d we=%b cnt=%0d want %h/%0d/1/%0d",
                             i, o_data, o_addr, o_we, o_cnt, vals[i], i + 20, exp_cnt);
      end
    end
    set_in(1'b0, 2'b00, 64'h5, '0, '0, 3'b000, 3'd0, 1'b1, 5'd6);
    tick();
    checks++;
    if ({o_we, o_valid, o_cnt} !== {1'b0, 1'b0, exp_cnt}) begin
      failures++; $display("FAIL bubble we=%b v=%b cnt=%0d want 0/0/%0d", o_we, o_valid, o_cnt, exp_cnt);
    end
    idle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_counter_wrap();
    idle();
    @(negedge clk); rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_cnt = 0;
    set_in(1'b1, 2'b00, 64'h9, '0, '0, 3'b000, 3'd0, 1'b1, 5'd1);
    for (int i = 1; i <= 17; i++) begin
      tick(); exp_cnt++;
      if (i == 15) begin
        checks++;
        if (c4_cnt !== 4'd15) begin
          failures++; $display("FAIL wrap_15 cnt=%0d want 15", c4_cnt);
        end
      end
      if (i == 16) begin
        checks++;
        if (c4_cnt !== 4'd0) begin
          failures++; $display("FAIL wrap_16 cnt=%0d want 0", c4_cnt);
        end
      end
    end
    checks++;
    if (c4_cnt !== 4'd1) begin
      failures++; $display("FAIL wrap_17 cnt=%0d want 1", c4_cnt);
    end
    checks++;
    if (o_cnt !== 64'd17) begin
      failures++; $display("FAIL wide_17 cnt=%0d want 17", o_cnt);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_reset_mid_stall();
    test_load_ext();
    test_source_select();
    test_misaligned();
    test_stall_flush();
    test_back_to_back();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
